// File: rtl/reset_req_pkg.sv
// Shared constants and state encoding for the reset-request initiator.
package reset_req_pkg;

    localparam logic [31:0] RESET_WORD_DEFAULT = 32'h5555_5555;
    localparam int          TIMER_W            = 16;

    // One-hot states; any other pattern is treated as corrupted and recovered through CLEAR.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_ASSERT  = 4'b0010,
        ST_RELEASE = 4'b0100,
        ST_CLEAR   = 4'b1000
    } state_t;

    function automatic logic word_active(input state_t s);
        return (s == ST_ASSERT) || (s == ST_RELEASE);
    endfunction

endpackage

// File: rtl/reset_req_timer.sv
// Wait-cycle counter: synchronous clear, count enable, expire flag when count == limit-1.
module reset_req_timer
    import reset_req_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_enable,
    input  logic [TIMER_W-1:0] i_limit,
    output logic               o_expire,
    output logic [TIMER_W-1:0] o_count_next
);

    logic [TIMER_W-1:0] r_count;
    logic [TIMER_W-1:0] w_count_next;

    always_comb begin
        w_count_next = r_count;
        if (i_clear) begin
            w_count_next = '0;
        end else if (i_enable) begin
            w_count_next = r_count + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_expire     = (r_count == (i_limit - TIMER_W'(1)));
    assign o_count_next = w_count_next;

endmodule

// File: rtl/reset_requester.sv
// Drives the magic reset-request word, waits for the looped-back reset pulse, then clears it.
// Must sit outside the reset it requests. Optional timeout retries: define RESET_REQ_RETRY_EN.
module reset_requester
    import reset_req_pkg::*;
#(
    parameter logic [31:0] RESET_WORD   = RESET_WORD_DEFAULT,
    parameter int          TIMEOUT      = 64,
    parameter int          CLEAR_CYCLES = 2,
    parameter int          MAX_RETRIES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqStart,
    input  logic        resetObserved,
    output logic [31:0] resetRequestWord,
    output logic        busy,
    output logic        done,
    output logic        timeoutErr
);

    localparam logic [TIMER_W-1:0] TIMEOUT_LIMIT = TIMER_W'(TIMEOUT);
    localparam logic [TIMER_W-1:0] CLEAR_LIMIT   = TIMER_W'(CLEAR_CYCLES);
    localparam logic [TIMER_W-1:0] CLEAR_LAST    = TIMER_W'(CLEAR_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [31:0]        r_word;
    logic [31:0]        w_word_next;
    logic               r_busy;
    logic               w_busy_next;
    logic               r_done;
    logic               w_done_next;
    logic               r_timeout_err;
    logic               w_timeout_err_next;
    logic               r_aborted;
    logic               w_aborted_next;

    logic               w_accept;
    logic               w_abort;
    logic               w_enter_clear;
    logic               w_last_clear_next;
    logic               w_retry_avail;
    logic               w_retry_pending;
    logic               w_retry_next;

    logic               w_tmr_clear;
    logic               w_tmr_enable;
    logic [TIMER_W-1:0] w_tmr_limit;
    logic               w_tmr_expire;
    logic [TIMER_W-1:0] w_tmr_count_next;

    assign w_accept     = (r_state == ST_IDLE) && reqStart;
    assign w_tmr_clear  = (w_state_next != r_state);
    assign w_tmr_enable = (r_state != ST_IDLE);
    assign w_tmr_limit  = (r_state == ST_CLEAR) ? CLEAR_LIMIT : TIMEOUT_LIMIT;

    reset_req_timer u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_tmr_clear),
        .i_enable     (w_tmr_enable),
        .i_limit      (w_tmr_limit),
        .o_expire     (w_tmr_expire),
        .o_count_next (w_tmr_count_next)
    );

    // Next-state: the protocol response always takes priority over a timer expiring in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (reqStart) begin
                    w_state_next = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (resetObserved) begin
                    w_state_next = ST_RELEASE;
                end else if (w_tmr_expire) begin
                    w_state_next = ST_CLEAR;
                    w_abort      = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!resetObserved) begin
                    w_state_next = ST_CLEAR;
                end else if (w_tmr_expire) begin
                    w_state_next = ST_CLEAR;
                    w_abort      = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (w_tmr_expire) begin
                    w_state_next = w_retry_pending ? ST_ASSERT : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_CLEAR;
                w_abort      = 1'b1;
            end
        endcase
    end

    // Outputs are precomputed from the next state so that done/timeoutErr land in the final CLEAR cycle.
    always_comb begin
        w_enter_clear      = (w_state_next == ST_CLEAR) && (r_state != ST_CLEAR);
        w_retry_next       = w_enter_clear ? (w_abort && w_retry_avail) : w_retry_pending;
        w_aborted_next     = w_enter_clear ? (w_abort && !w_retry_avail) : r_aborted;
        w_last_clear_next  = (w_state_next == ST_CLEAR) && (w_tmr_count_next == CLEAR_LAST);
        w_word_next        = word_active(w_state_next) ? RESET_WORD : 32'h0;
        w_busy_next        = (w_state_next != ST_IDLE);
        w_done_next        = w_last_clear_next && !w_aborted_next && !w_retry_next;
        w_timeout_err_next = r_timeout_err;
        if (w_accept) begin
            w_timeout_err_next = 1'b0;
        end else if (w_last_clear_next && w_aborted_next) begin
            w_timeout_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_word        <= 32'h0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_aborted     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_word        <= w_word_next;
            r_busy        <= w_busy_next;
            r_done        <= w_done_next;
            r_timeout_err <= w_timeout_err_next;
            r_aborted     <= w_aborted_next;
        end
    end

`ifdef RESET_REQ_RETRY_EN
    localparam logic [TIMER_W-1:0] RETRY_LIMIT = TIMER_W'(MAX_RETRIES);

    logic [TIMER_W-1:0] r_retry_cnt;
    logic               r_retry_pending;

    assign w_retry_avail   = (r_retry_cnt < RETRY_LIMIT);
    assign w_retry_pending = r_retry_pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retry_cnt     <= '0;
            r_retry_pending <= 1'b0;
        end else begin
            if (w_accept) begin
                r_retry_cnt <= '0;
            end else if (w_enter_clear && w_abort && w_retry_avail) begin
                r_retry_cnt <= r_retry_cnt + TIMER_W'(1);
            end
            r_retry_pending <= w_retry_next;
        end
    end
`else
    logic w_unused_retry_cfg;

    assign w_retry_avail      = 1'b0;
    assign w_retry_pending    = 1'b0;
    assign w_unused_retry_cfg = (MAX_RETRIES < 0);
`endif

    assign resetRequestWord = r_word;
    assign busy             = r_busy;
    assign done             = r_done;
    assign timeoutErr       = r_timeout_err;

endmodule

// File: tb/tb_reset_requester.sv
// Directed bench for reset_requester; done/timeoutErr events are checked by a scoreboard monitor.
module tb_reset_requester;

    localparam logic [31:0] RW  = 32'h5555_5555;
    localparam int          TO  = 64;
    localparam int          CLR = 2;
`ifdef RESET_REQ_RETRY_EN
    localparam int          NWIN = 3;
`else
    localparam int          NWIN = 1;
`endif
    localparam int          WIN_LOW  = TO + CLR;
    localparam int          WIN_HIGH = TO + CLR + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqStart;
    logic        resetObserved;
    logic [31:0] resetRequestWord;
    logic        busy;
    logic        done;
    logic        timeoutErr;

    reset_requester #(
        .RESET_WORD   (RW),
        .TIMEOUT      (TO),
        .CLEAR_CYCLES (CLR),
        .MAX_RETRIES  (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .reqStart         (reqStart),
        .resetObserved    (resetObserved),
        .resetRequestWord (resetRequestWord),
        .busy             (busy),
        .done             (done),
        .timeoutErr       (timeoutErr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_DONE, EV_TERR} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       at;
    } ev_t;

    ev_t  exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   t;
    logic prev_terr = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_t kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic match_ev(input ev_kind_t kind);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got %s at cycle %0d expected none", kind.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.at != cyc) begin
                n_err++;
                $display("FAIL event: got %s at cycle %0d expected %s at cycle %0d",
                         kind.name(), cyc, e.kind.name(), e.at);
            end else begin
                $display("event %s at cycle %0d ok", kind.name(), cyc);
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        reqStart      = 1'b0;
        resetObserved = 1'b0;
        fork
            begin : stim
                repeat (3) tick();
                check("rst_word", resetRequestWord, 32'h0);
                check("rst_busy", 32'(busy), 32'h0);
                check("rst_done", 32'(done), 32'h0);
                check("rst_terr", 32'(timeoutErr), 32'h0);
                reset = 1'b0;
                repeat (2) tick();

                // 1: normal handshake, pulse seen t+3..t+9
                t = cyc;
                expect_ev(EV_DONE, t + 10 + CLR);
                reqStart = 1'b1;
                tick();
                reqStart = 1'b0;
                for (int k = 1; k <= 14; k++) begin
                    if (k > 1) tick();
                    resetObserved = (k >= 3 && k <= 9);
                    check("t1_word", resetRequestWord, (k <= 10) ? RW : 32'h0);
                    check("t1_busy", 32'(busy), 32'(k <= 12));
                end
                resetObserved = 1'b0;

                // 2: no response; ASSERT-window timeouts (retried when enabled)
                t = cyc;
                expect_ev(EV_TERR, t + WIN_LOW * NWIN);
                reqStart = 1'b1;
                tick();
                reqStart = 1'b0;
                for (int k = 1; k <= WIN_LOW * NWIN + 2; k++) begin
                    int p;
                    if (k > 1) tick();
                    p = (k - 1) % WIN_LOW + 1;
                    check("t2_word", resetRequestWord,
                          (p <= TO && k <= WIN_LOW * NWIN) ? RW : 32'h0);
                    check("t2_busy", 32'(busy), 32'(k <= WIN_LOW * NWIN));
                end
                check("t2_terr_sticky", 32'(timeoutErr), 32'h1);

                // 3: resetObserved stuck high -> RELEASE timeout
                t = cyc;
                expect_ev(EV_TERR, t + WIN_HIGH * NWIN);
                resetObserved = 1'b1;
                reqStart = 1'b1;
                tick();
                reqStart = 1'b0;
                check("t3_terr_cleared", 32'(timeoutErr), 32'h0);
                for (int k = 1; k <= WIN_HIGH * NWIN + 2; k++) begin
                    int p;
                    if (k > 1) tick();
                    p = (k - 1) % WIN_HIGH + 1;
                    check("t3_word", resetRequestWord,
                          (p <= TO + 1 && k <= WIN_HIGH * NWIN) ? RW : 32'h0);
                end
                check("t3_terr_sticky", 32'(timeoutErr), 32'h1);

                // 7: pulse drops exactly as the RELEASE timer expires -> normal completion
                t = cyc;
                expect_ev(EV_DONE, t + TO + 1 + CLR);
                reqStart = 1'b1;
                tick();
                reqStart = 1'b0;
                for (int k = 1; k <= TO + CLR + 4; k++) begin
                    if (k > 1) tick();
                    resetObserved = (k < TO + 1);
                    check("t7_word", resetRequestWord, (k <= TO + 1) ? RW : 32'h0);
                    check("t7_busy", 32'(busy), 32'(k <= TO + 1 + CLR));
                end
                check("t7_terr", 32'(timeoutErr), 32'h0);
                resetObserved = 1'b0;

                // 4: second reqStart while busy is ignored
                t = cyc;
                expect_ev(EV_DONE, t + 4 + CLR);
                reqStart = 1'b1;
                tick();
                for (int k = 1; k <= 12; k++) begin
                    if (k > 1) tick();
                    reqStart      = (k == 3);
                    resetObserved = (k == 2 || k == 3);
                    check("t4_word", resetRequestWord, (k <= 4) ? RW : 32'h0);
                    check("t4_busy", 32'(busy), 32'(k <= 4 + CLR));
                end
                reqStart      = 1'b0;
                resetObserved = 1'b0;

                // 5: reset in RELEASE, then reset together with reqStart
                t = cyc;
                reqStart = 1'b1;
                tick();
                reqStart = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    if (k > 1) tick();
                    resetObserved = 1'b1;
                    check("t5_word", resetRequestWord, RW);
                end
                reset = 1'b1;
                tick();
                check("t5_rst_word", resetRequestWord, 32'h0);
                check("t5_rst_busy", 32'(busy), 32'h0);
                check("t5_rst_done", 32'(done), 32'h0);
                check("t5_rst_terr", 32'(timeoutErr), 32'h0);
                reqStart = 1'b1;
                tick();
                check("t5_both_word", resetRequestWord, 32'h0);
                check("t5_both_busy", 32'(busy), 32'h0);
                reset         = 1'b0;
                reqStart      = 1'b0;
                resetObserved = 1'b0;
                tick();
                check("t5_idle_word", resetRequestWord, 32'h0);
                check("t5_idle_busy", 32'(busy), 32'h0);
                repeat (4) tick();
            end
            begin : mon
                forever begin
                    @(negedge clk);
                    n_vec++;
                    if (resetRequestWord !== 32'h0 && resetRequestWord !== RW) begin
                        n_err++;
                        $display("FAIL word_legal cycle %0d: got %h expected 0 or %h",
                                 cyc, resetRequestWord, RW);
                    end
                    if (done === 1'b1) match_ev(EV_DONE);
                    if (timeoutErr === 1'b1 && prev_terr === 1'b0) match_ev(EV_TERR);
                    prev_terr = timeoutErr;
                end
            end
        join_any
        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_event: got nothing expected %s at cycle %0d", e.kind.name(), e.at);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got no end of stimulus expected completion within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
